// File: rtl/rv32i_types.sv
// Shared RV32I opcode constants and the reorder-buffer entry layout.
package rv32i_types;

  localparam logic [6:0] store_opcode = 7'b0100011;
  localparam logic [6:0] br_opcode    = 7'b1100011;
  localparam logic [6:0] jal_opcode   = 7'b1101111;
  localparam logic [6:0] jalr_opcode  = 7'b1100111;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        mispredict;
    logic [6:0]  opcode;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic [31:0] target;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, completes from the CDB,
// commits from head and requests a pipeline flush on a mispredicted head.
module reorder_buffer
  import rv32i_types::*;
#(
  parameter int ROB_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  input  logic [6:0]           alloc_opcode,
  input  logic [4:0]           alloc_rd_s,
  output logic                 alloc_ready,
  output logic [ROB_DEPTH-1:0] alloc_rob,
  input  logic                 cdb_valid,
  input  logic [ROB_DEPTH-1:0] cdb_rob,
  input  logic [31:0]          cdb_rd_v,
  input  logic                 cdb_mispredict,
  input  logic [31:0]          cdb_target,
  input  logic [ROB_DEPTH-1:0] rs1_rob,
  input  logic [ROB_DEPTH-1:0] rs2_rob,
  output logic                 rs1_rob_ready,
  output logic                 rs2_rob_ready,
  output logic [31:0]          rs1_rob_v,
  output logic [31:0]          rs2_rob_v,
  output logic                 commit_regfile_we,
  output logic [4:0]           commit_rd_s,
  output logic [31:0]          commit_rd_v,
  output logic [ROB_DEPTH-1:0] commit_rob,
  output logic                 move_flush,
  output logic [31:0]          flush_pc
);

  localparam int N = 1 << ROB_DEPTH;
  localparam logic [ROB_DEPTH:0] PTR_ONE = {{ROB_DEPTH{1'b0}}, 1'b1};

  rob_entry_t rob_q [N];
  rob_entry_t rob_d [N];

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [ROB_DEPTH:0] head_q, head_d;
  logic [ROB_DEPTH:0] tail_q, tail_d;

  logic [ROB_DEPTH-1:0] head_idx;
  logic [ROB_DEPTH-1:0] tail_idx;
  logic                 full;
  logic                 commit;
  logic                 flush;
  logic                 alloc_fire;
  rob_entry_t           head_entry;

  assign head_idx   = head_q[ROB_DEPTH-1:0];
  assign tail_idx   = tail_q[ROB_DEPTH-1:0];
  assign full       = (head_idx == tail_idx) && (head_q[ROB_DEPTH] != tail_q[ROB_DEPTH]);
  assign head_entry = rob_q[head_idx];
  assign commit     = head_entry.valid && head_entry.done;
  assign flush      = commit && head_entry.mispredict;
  assign alloc_fire = alloc_valid && !full;

  assign alloc_ready = !full;
  assign alloc_rob   = tail_idx;

  assign commit_regfile_we = commit && (head_entry.opcode != store_opcode)
                                    && (head_entry.opcode != br_opcode);
  assign commit_rd_s = head_entry.rd_s;
  assign commit_rd_v = head_entry.rd_v;
  assign commit_rob  = head_idx;
  assign move_flush  = flush;
  assign flush_pc    = head_entry.target;

  // Lookups see registered state only; a same-cycle CDB result is not forwarded.
  assign rs1_rob_ready = rob_q[rs1_rob].valid && rob_q[rs1_rob].done;
  assign rs2_rob_ready = rob_q[rs2_rob].valid && rob_q[rs2_rob].done;
  assign rs1_rob_v     = rob_q[rs1_rob].rd_v;
  assign rs2_rob_v     = rob_q[rs2_rob].rd_v;

  always_comb begin
    rob_d  = rob_q;
    head_d = head_q;
    tail_d = tail_q;
    if (flush) begin
      // Everything younger than the mispredicted head is squashed,
      // including whatever tried to allocate or complete this cycle.
      for (int i = 0; i < N; i++) begin
        rob_d[i].valid      = 1'b0;
        rob_d[i].done       = 1'b0;
        rob_d[i].mispredict = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
    end else begin
      if (commit) begin
        rob_d[head_idx].valid = 1'b0;
        head_d = head_q + PTR_ONE;
      end
      if (cdb_valid && rob_q[cdb_rob].valid) begin
        rob_d[cdb_rob].done       = 1'b1;
        rob_d[cdb_rob].rd_v       = cdb_rd_v;
        rob_d[cdb_rob].mispredict = cdb_mispredict;
        rob_d[cdb_rob].target     = cdb_target;
      end
      if (alloc_fire) begin
        rob_d[tail_idx].valid      = 1'b1;
        rob_d[tail_idx].done       = 1'b0;
        rob_d[tail_idx].mispredict = 1'b0;
        rob_d[tail_idx].opcode     = alloc_opcode;
        rob_d[tail_idx].rd_s       = alloc_rd_s;
        tail_d = tail_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < N; i++) begin
        rob_q[i] <= '0;
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      for (int i = 0; i < N; i++) begin
        rob_q[i] <= rob_d[i];
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench: stimulus queues expected commits, a negedge monitor retires them.
module tb_reorder_buffer;
  import rv32i_types::*;

  localparam logic [6:0] OP_R = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_valid = 1'b0;
  logic [6:0]  alloc_opcode = '0;
  logic [4:0]  alloc_rd_s = '0;
  logic        alloc_ready;
  logic [3:0]  alloc_rob;
  logic        cdb_valid = 1'b0;
  logic [3:0]  cdb_rob = '0;
  logic [31:0] cdb_rd_v = '0;
  logic        cdb_mispredict = 1'b0;
  logic [31:0] cdb_target = '0;
  logic [3:0]  rs1_rob = '0;
  logic [3:0]  rs2_rob = '0;
  logic        rs1_rob_ready, rs2_rob_ready;
  logic [31:0] rs1_rob_v, rs2_rob_v;
  logic        commit_regfile_we;
  logic [4:0]  commit_rd_s;
  logic [31:0] commit_rd_v;
  logic [3:0]  commit_rob;
  logic        move_flush;
  logic [31:0] flush_pc;

  reorder_buffer #(.ROB_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_opcode(alloc_opcode), .alloc_rd_s(alloc_rd_s),
    .alloc_ready(alloc_ready), .alloc_rob(alloc_rob),
    .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_rd_v(cdb_rd_v),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .rs1_rob(rs1_rob), .rs2_rob(rs2_rob),
    .rs1_rob_ready(rs1_rob_ready), .rs2_rob_ready(rs2_rob_ready),
    .rs1_rob_v(rs1_rob_v), .rs2_rob_v(rs2_rob_v),
    .commit_regfile_we(commit_regfile_we), .commit_rd_s(commit_rd_s),
    .commit_rd_v(commit_rd_v), .commit_rob(commit_rob),
    .move_flush(move_flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        flush;
    logic [4:0]  rd_s;
    logic [31:0] rd_v;
    logic [3:0]  rob;
    logic [31:0] pc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_commit(input logic we, input logic fl, input logic [4:0] rd,
                               input logic [31:0] v, input logic [3:0] rob, input logic [31:0] pc);
    exp_t e;
    e.we = we; e.flush = fl; e.rd_s = rd; e.rd_v = v; e.rob = rob; e.pc = pc;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic alloc(input logic [6:0] op, input logic [4:0] rd);
    alloc_valid = 1'b1; alloc_opcode = op; alloc_rd_s = rd;
    tick();
    alloc_valid = 1'b0;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] v, input logic mp, input logic [31:0] tgt);
    cdb_valid = 1'b1; cdb_rob = tag; cdb_rd_v = v; cdb_mispredict = mp; cdb_target = tgt;
    tick();
    cdb_valid = 1'b0; cdb_mispredict = 1'b0;
  endtask

  // Monitor: every visible register write or flush must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (commit_regfile_we || move_flush)) begin
      checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_commit: got we=%0b flush=%0b rob=%0d expected none",
                 commit_regfile_we, move_flush, commit_rob);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (commit_regfile_we === e.we && move_flush === e.flush && commit_rd_s === e.rd_s &&
            commit_rd_v === e.rd_v && commit_rob === e.rob && (!e.flush || flush_pc === e.pc)) begin
          passed++;
          $display("commit rob=%0d we=%0b rd=%0d v=%08h flush=%0b", commit_rob,
                   commit_regfile_we, commit_rd_s, commit_rd_v, move_flush);
        end else begin
          $display("FAIL commit: got we=%0b fl=%0b rd=%0d v=%08h rob=%0d pc=%08h expected we=%0b fl=%0b rd=%0d v=%08h rob=%0d pc=%08h",
                   commit_regfile_we, move_flush, commit_rd_s, commit_rd_v, commit_rob, flush_pc,
                   e.we, e.flush, e.rd_s, e.rd_v, e.rob, e.pc);
        end
      end
    end
  end

  initial begin
    // Reset state
    tick();
    do_reset();
    check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    check("rst_alloc_rob", 32'(alloc_rob), 32'd0);
    check("rst_we", 32'(commit_regfile_we), 32'd0);
    check("rst_flush", 32'(move_flush), 32'd0);
    check("rst_rs1_ready", 32'(rs1_rob_ready), 32'd0);
    check("rst_rs2_ready", 32'(rs2_rob_ready), 32'd0);

    // Fill all 16 entries with no completions
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fill_rob_%0d", i), 32'(alloc_rob), 32'(i));
      check($sformatf("fill_ready_%0d", i), 32'(alloc_ready), 32'd1);
      alloc(OP_R, 5'(i));
    end
    check("full_ready", 32'(alloc_ready), 32'd0);
    rs1_rob = 4'd3;
    check("full_lookup_not_done", 32'(rs1_rob_ready), 32'd0);
    alloc(OP_R, 5'd31);
    check("full_refused_ready", 32'(alloc_ready), 32'd0);
    // Reset wins over a same-cycle allocation
    rst = 1'b1; alloc_valid = 1'b1;
    tick();
    rst = 1'b0; alloc_valid = 1'b0;
    check("midrst_ready", 32'(alloc_ready), 32'd1);
    check("midrst_rob", 32'(alloc_rob), 32'd0);

    // Single alloc + complete, one-cycle latency to commit
    alloc(OP_R, 5'd5);
    cdb_valid = 1'b1; cdb_rob = 4'd0; cdb_rd_v = 32'hDEAD_BEEF;
    #1;
    check("no_cdb_bypass_we", 32'(commit_regfile_we), 32'd0);
    expect_commit(1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 4'd0, 32'd0);
    tick();
    cdb_valid = 1'b0;
    check("single_we", 32'(commit_regfile_we), 32'd1);
    tick();
    check("single_empty_we", 32'(commit_regfile_we), 32'd0);
    check("single_tail", 32'(alloc_rob), 32'd1);

    // Out-of-order completion retires in order
    do_reset();
    alloc(OP_R, 5'd7);
    alloc(OP_R, 5'd8);
    cdb(4'd1, 32'h0000_0011, 1'b0, 32'd0);
    check("ooo_no_commit", 32'(commit_regfile_we), 32'd0);
    rs1_rob = 4'd1; rs2_rob = 4'd0;
    #1;
    check("ooo_rs1_ready", 32'(rs1_rob_ready), 32'd1);
    check("ooo_rs1_v", rs1_rob_v, 32'h0000_0011);
    check("ooo_rs2_ready", 32'(rs2_rob_ready), 32'd0);
    expect_commit(1'b1, 1'b0, 5'd7, 32'h0000_0022, 4'd0, 32'd0);
    expect_commit(1'b1, 1'b0, 5'd8, 32'h0000_0011, 4'd1, 32'd0);
    cdb(4'd0, 32'h0000_0022, 1'b0, 32'd0);
    tick();
    tick();
    check("ooo_head_after", 32'(commit_rob), 32'd2);
    check("ooo_idle_we", 32'(commit_regfile_we), 32'd0);

    // Mispredicted branch at head flushes and squashes same-cycle traffic
    do_reset();
    alloc(br_opcode, 5'd0);
    alloc(OP_R, 5'd9);
    expect_commit(1'b0, 1'b1, 5'd0, 32'd0, 4'd0, 32'h6000_0040);
    cdb(4'd0, 32'd0, 1'b1, 32'h6000_0040);
    check("br_flush", 32'(move_flush), 32'd1);
    check("br_pc", flush_pc, 32'h6000_0040);
    check("br_we", 32'(commit_regfile_we), 32'd0);
    alloc_valid = 1'b1; alloc_opcode = OP_R; alloc_rd_s = 5'd3;
    cdb_valid = 1'b1; cdb_rob = 4'd1; cdb_rd_v = 32'h5555_5555;
    tick();
    alloc_valid = 1'b0; cdb_valid = 1'b0;
    rs1_rob = 4'd1; rs2_rob = 4'd2;
    #1;
    check("post_flush_rob", 32'(alloc_rob), 32'd0);
    check("post_flush_ready", 32'(alloc_ready), 32'd1);
    check("post_flush_head", 32'(commit_rob), 32'd0);
    check("post_flush_noflush", 32'(move_flush), 32'd0);
    check("post_flush_rs1", 32'(rs1_rob_ready), 32'd0);
    check("post_flush_rs2", 32'(rs2_rob_ready), 32'd0);

    // Full ROB: commit happens but allocation refused that cycle
    do_reset();
    for (int i = 0; i < 16; i++) alloc(OP_R, 5'(i + 1));
    expect_commit(1'b1, 1'b0, 5'd1, 32'h0000_00A0, 4'd0, 32'd0);
    cdb(4'd0, 32'h0000_00A0, 1'b0, 32'd0);
    check("full_commit_ready", 32'(alloc_ready), 32'd0);
    alloc(OP_R, 5'd20);
    check("full_after_ready", 32'(alloc_ready), 32'd1);
    check("full_after_tail", 32'(alloc_rob), 32'd0);
    check("full_after_head", 32'(commit_rob), 32'd1);
    // Simultaneous alloc and commit keeps occupancy
    expect_commit(1'b1, 1'b0, 5'd2, 32'h0000_00B1, 4'd1, 32'd0);
    cdb(4'd1, 32'h0000_00B1, 1'b0, 32'd0);
    alloc(OP_R, 5'd21);
    check("simul_ready", 32'(alloc_ready), 32'd1);
    check("simul_tail", 32'(alloc_rob), 32'd1);
    check("simul_head", 32'(commit_rob), 32'd2);

    // Store retires without a register write; ignored CDB to invalid tag
    do_reset();
    cdb(4'd5, 32'hFFFF_FFFF, 1'b0, 32'd0);
    rs1_rob = 4'd5;
    #1;
    check("cdb_invalid_ignored", 32'(rs1_rob_ready), 32'd0);
    alloc(store_opcode, 5'd0);
    cdb(4'd0, 32'h1234_5678, 1'b0, 32'd0);
    rs1_rob = 4'd0;
    #1;
    check("st_rs1_ready", 32'(rs1_rob_ready), 32'd1);
    check("st_rs1_v", rs1_rob_v, 32'h1234_5678);
    check("st_we", 32'(commit_regfile_we), 32'd0);
    check("st_head", 32'(commit_rob), 32'd0);
    tick();
    check("st_head_adv", 32'(commit_rob), 32'd1);
    check("st_rs1_cleared", 32'(rs1_rob_ready), 32'd0);

    tick();
    tick();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter ROB_DEPTH, default 4, ROB tag width in bits; entry count N = 2**ROB_DEPTH.
REQ-002 clk  in  1  clock, all state updates on rising edge.
REQ-003 rst  in  1  reset: rst, synchronous, active-high; clock clk.
REQ-004 alloc_valid  in  1  issue stage requests a new entry this cycle.
REQ-005 alloc_opcode  in  7  opcode of the allocating instruction.
REQ-006 alloc_rd_s  in  5  destination architectural register.
REQ-007 alloc_ready  out  1  high when the ROB is not full.
REQ-008 alloc_rob  out  ROB_DEPTH  tag of the entry granted, equal to the tail index.
REQ-009 cdb_valid  in  1  a functional unit broadcasts a result.
REQ-010 cdb_rob  in  ROB_DEPTH  tag being completed.
REQ-011 cdb_rd_v  in  32  result value.
REQ-012 cdb_mispredict  in  1  completed branch/jump was mispredicted.
REQ-013 cdb_target  in  32  corrected PC for a mispredicted branch.
REQ-014 rs1_rob, rs2_rob  in  ROB_DEPTH each  operand tags looked up by issue.
REQ-015 rs1_rob_ready, rs2_rob_ready  out  1 each  looked-up entry is valid and done.
REQ-016 rs1_rob_v, rs2_rob_v  out  32 each  value stored in the looked-up entry.
REQ-017 commit_regfile_we  out  1  head commits a register-writing instruction.
REQ-018 commit_rd_s  out  5  head destination register.
REQ-019 commit_rd_v  out  32  head result value.
REQ-020 commit_rob  out  ROB_DEPTH  head tag.
REQ-021 move_flush  out  1  pipeline flush request.
REQ-022 flush_pc  out  32  redirect PC, valid while move_flush is high.

Function
REQ-023 Storage: N entries, each holding valid, done, mispredict, opcode, rd_s, rd_v, and target.
- Head and tail pointers are ROB_DEPTH+1 bits; the MSB is the wrap bit.
- Empty when head equals tail; full when the index bits are equal and the wrap bits differ.
REQ-024 Allocation: when alloc_valid and alloc_ready, at the edge the tail entry is written with valid=1, done=0, and the opcode and rd; tail then increments.
- alloc_ready depends only on full; it does not depend on a same-cycle commit.
REQ-025 Completion: when cdb_valid and the entry at cdb_rob is valid, at the edge the entry is written with done=1, rd_v=cdb_rd_v, mispredict=cdb_mispredict, and target=cdb_target.
- A CDB write to an invalid entry is ignored.
REQ-026 Commit condition: commit fires when the head entry is valid and done, and is evaluated combinationally from registered state; at most one commit per cycle.
- Latency: a CDB write in cycle T is visible at commit no earlier than cycle T+1.
REQ-027 Commit outputs: commit_regfile_we = commit AND the head opcode is neither store_opcode nor br_opcode; rd_s=0 is passed through unchanged.
- commit_rd_s, commit_rd_v, and commit_rob always reflect the head entry.
REQ-028 On commit: the head entry's valid is cleared and head increments.
REQ-029 Flush: move_flush = commit AND the head's mispredict bit; flush_pc = the head's target.
- At that edge all valid bits are cleared, head=tail=0, and any same-cycle allocation or CDB write is discarded.
REQ-030 Operand lookup: lookup is combinational, with ready = valid AND done of the indexed entry.
- There is no same-cycle bypass from the CDB.
REQ-031 Simultaneous allocation and commit when non-empty and non-full: both occur and the occupancy is unchanged.

Reset
REQ-032 On rst: head=tail=0, all valid, done, and mispredict bits cleared, and stored values zeroed.
REQ-033 After reset the outputs are: alloc_ready=1, alloc_rob=0, commit_regfile_we=0, move_flush=0, and the rs*_rob_ready outputs=0.
REQ-034 rst asserted mid-operation takes precedence over allocation, CDB write, commit, and flush in the same cycle.

Structure
REQ-035 store_opcode, br_opcode, jal/jalr opcodes, and a rob_entry_t struct shall reside in package rv32i_types.
REQ-036 The block is a single module with no sub-modules; the pointer and full/empty logic is inline.

Verification
REQ-037 Reset, then allocate 16 entries with no completions -> alloc_ready falls after the 16th grant and alloc_rob sequences 0..15.
REQ-038 Allocate rd=5, then CDB tag 0 with value 0xDEAD_BEEF -> next cycle commit_regfile_we=1, commit_rd_s=5, commit_rd_v=0xDEADBEEF, commit_rob=0.
REQ-039 Allocate tags 0 and 1, complete tag 1 first -> no commit until tag 0 completes, then two consecutive commits in order.
REQ-040 Head is a branch completed with mispredict and target 0x6000_0040 -> move_flush=1, flush_pc=0x60000040, commit_regfile_we=0; next cycle empty, alloc_rob=0.
REQ-041 Full ROB with the head done plus alloc_valid -> the commit occurs and the allocation is refused that cycle; alloc_ready=1 in the next cycle.
REQ-042 Store at head completed -> commit occurs with commit_regfile_we=0; an rs1_rob lookup of the completed tag returns ready=1 with the stored value.
